vx_mem_credit_gate: RTL and testbench

VX_MEM_CREDIT_GATE -- requirements
Module: VX_mem_credit_gate

---
 rtl/vx_mem_credit_gate.sv | 215 +++++++++++++++++++++
 tb/tb_vx_mem_credit_gate.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_credit_gate.sv
// vx_mem_credit_gate: credit-limited memory request gate.
// Requests pass through a 2-entry elastic buffer. Reads consume a credit until
// their response returns. A flush FSM drains all outstanding reads.
// Optional performance counters are enabled by defining VX_MEM_CREDIT_PERF_EN.
module vx_mem_credit_gate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_SIZE   = 64,
    parameter int TAG_WIDTH   = 16,
    parameter int MAX_PENDING = 16
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             in_req_valid,
    output logic                             in_req_ready,
    input  logic                             in_req_rw,
    input  logic [ADDR_WIDTH-1:0]            in_req_addr,
    input  logic [8*DATA_SIZE-1:0]           in_req_data,
    input  logic [DATA_SIZE-1:0]             in_req_byteen,
    input  logic [TAG_WIDTH-1:0]             in_req_tag,

    output logic                             out_req_valid,
    input  logic                             out_req_ready,
    output logic                             out_req_rw,
    output logic [ADDR_WIDTH-1:0]            out_req_addr,
    output logic [8*DATA_SIZE-1:0]           out_req_data,
    output logic [DATA_SIZE-1:0]             out_req_byteen,
    output logic [TAG_WIDTH-1:0]             out_req_tag,

    input  logic                             in_rsp_valid,
    output logic                             in_rsp_ready,
    input  logic [8*DATA_SIZE-1:0]           in_rsp_data,
    input  logic [TAG_WIDTH-1:0]             in_rsp_tag,

    output logic                             out_rsp_valid,
    input  logic                             out_rsp_ready,
    output logic [8*DATA_SIZE-1:0]           out_rsp_data,
    output logic [TAG_WIDTH-1:0]             out_rsp_tag,

    input  logic                             flush_req,
    output logic                             flush_done,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             busy
`ifdef VX_MEM_CREDIT_PERF_EN
    ,
    output logic [43:0]                      perf_stall_cycles,
    output logic [$clog2(MAX_PENDING+1)-1:0] perf_peak_pending
`endif
);

    localparam int unsigned PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] MAX_CREDITS = PW'(MAX_PENDING);

    typedef struct packed {
        logic                   rw;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [8*DATA_SIZE-1:0] data;
        logic [DATA_SIZE-1:0]   byteen;
        logic [TAG_WIDTH-1:0]   tag;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    req_t          buf_q [2];
    req_t          buf_d [2];
    req_t          head;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] pending_q, pending_d;
    state_t        state_q, state_d;

    logic buf_full;
    logic credit_ok;
    logic push;
    logic pop;
    logic rd_inc;
    logic rsp_dec;

    // Handshake qualification; all outputs are forced idle while reset is high.
    always_comb begin
        buf_full      = (cnt_q == 2'd2);
        credit_ok     = in_req_rw || (pending_q < MAX_CREDITS);
        in_req_ready  = !reset && !buf_full && (state_q == ST_IDLE) && credit_ok;
        push          = in_req_valid && in_req_ready;
        out_req_valid = !reset && (cnt_q != 2'd0);
        pop           = out_req_valid && out_req_ready;
        rd_inc        = push && !in_req_rw;
        rsp_dec       = in_rsp_valid && out_rsp_ready && (pending_q != '0);
        head          = buf_q[rd_ptr_q];
    end

    // Response path is a pure combinational pass-through.
    always_comb begin
        out_rsp_valid = in_rsp_valid;
        in_rsp_ready  = out_rsp_ready;
        out_rsp_data  = in_rsp_data;
        out_rsp_tag   = in_rsp_tag;
    end

    // Head of the elastic buffer drives the downstream request.
    always_comb begin
        out_req_rw     = head.rw;
        out_req_addr   = head.addr;
        out_req_data   = head.data;
        out_req_byteen = head.byteen;
        out_req_tag    = head.tag;
    end

    // Next-state for buffer storage, pointers, occupancy and credit count.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (push) begin
            buf_d[wr_ptr_q] = '{rw:     in_req_rw,
                                addr:   in_req_addr,
                                data:   in_req_data,
                                byteen: in_req_byteen,
                                tag:    in_req_tag};
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        pending_d = pending_q;
        case ({rd_inc, rsp_dec})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Flush FSM next state; drain completion looks at post-update occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if ((cnt_d == 2'd0) && (pending_d == '0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs derived from registered state.
    always_comb begin
        flush_done = !reset && (state_q == ST_DONE);
        busy       = !reset && ((pending_q != '0) || (cnt_q != 2'd0) || (state_q != ST_IDLE));
        pending    = pending_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    // Buffer payload storage; contents are qualified by cnt_q so need no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // A response with no outstanding read indicates an upstream protocol error.
    assert property (@(posedge clk) disable iff (reset)
                     (in_rsp_valid && out_rsp_ready) |-> (pending_q != '0));

`ifdef VX_MEM_CREDIT_PERF_EN
    logic [43:0]   stall_q, stall_d;
    logic [PW-1:0] peak_q, peak_d;
    logic          credit_stall;

    // Count stalls caused only by credit exhaustion; track peak credit usage.
    always_comb begin
        credit_stall = in_req_valid && !in_req_rw && !buf_full &&
                       (state_q == ST_IDLE) && (pending_q == MAX_CREDITS);
        stall_d = stall_q;
        if (credit_stall && (stall_q != '1)) stall_d = stall_q + 44'd1;
        peak_d = peak_q;
        if (pending_q > peak_q) peak_d = pending_q;
        perf_stall_cycles = stall_q;
        perf_peak_pending = peak_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            peak_q  <= '0;
        end else begin
            stall_q <= stall_d;
            peak_q  <= peak_d;
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_credit_gate.sv
// Testbench for vx_mem_credit_gate: directed scenarios with scoreboarded
// request and response streams.
module tb_vx_mem_credit_gate;

    localparam int AW = 32;
    localparam int DS = 8;
    localparam int TW = 16;
    localparam int MP = 4;
    localparam int PW = $clog2(MP + 1);

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [8*DS-1:0] data;
        logic [DS-1:0] byteen;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [8*DS-1:0] data;
        logic [TW-1:0]   tag;
    } rsp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_req_valid, in_req_ready, in_req_rw;
    logic [AW-1:0]   in_req_addr;
    logic [8*DS-1:0] in_req_data;
    logic [DS-1:0]   in_req_byteen;
    logic [TW-1:0]   in_req_tag;
    logic            out_req_valid, out_req_ready, out_req_rw;
    logic [AW-1:0]   out_req_addr;
    logic [8*DS-1:0] out_req_data;
    logic [DS-1:0]   out_req_byteen;
    logic [TW-1:0]   out_req_tag;
    logic            in_rsp_valid, in_rsp_ready;
    logic [8*DS-1:0] in_rsp_data;
    logic [TW-1:0]   in_rsp_tag;
    logic            out_rsp_valid, out_rsp_ready;
    logic [8*DS-1:0] out_rsp_data;
    logic [TW-1:0]   out_rsp_tag;
    logic            flush_req, flush_done, busy;
    logic [PW-1:0]   pending;
`ifdef VX_MEM_CREDIT_PERF_EN
    logic [43:0]     perf_stall_cycles;
    logic [PW-1:0]   perf_peak_pending;
`endif

    int errors = 0;
    int checks = 0;
    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];

    always #5 clk = ~clk;

    vx_mem_credit_gate #(
        .ADDR_WIDTH (AW),
        .DATA_SIZE  (DS),
        .TAG_WIDTH  (TW),
        .MAX_PENDING(MP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req_valid  (in_req_valid),
        .in_req_ready  (in_req_ready),
        .in_req_rw     (in_req_rw),
        .in_req_addr   (in_req_addr),
        .in_req_data   (in_req_data),
        .in_req_byteen (in_req_byteen),
        .in_req_tag    (in_req_tag),
        .out_req_valid (out_req_valid),
        .out_req_ready (out_req_ready),
        .out_req_rw    (out_req_rw),
        .out_req_addr  (out_req_addr),
        .out_req_data  (out_req_data),
        .out_req_byteen(out_req_byteen),
        .out_req_tag   (out_req_tag),
        .in_rsp_valid  (in_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .in_rsp_data   (in_rsp_data),
        .in_rsp_tag    (in_rsp_tag),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_ready (out_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_tag   (out_rsp_tag),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .pending       (pending),
        .busy          (busy)
`ifdef VX_MEM_CREDIT_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_peak_pending(perf_peak_pending)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic rw, input logic [15:0] tag);
        in_req_valid  = v;
        in_req_rw     = rw;
        in_req_tag    = tag;
        in_req_addr   = {16'hA000, tag};
        in_req_data   = {4{tag}} ^ 64'h0123_4567_89AB_CDEF;
        in_req_byteen = rw ? tag[7:0] : 8'hFF;
    endtask

    task automatic set_rsp(input logic v, input logic [15:0] tag);
        rsp_t r;
        in_rsp_valid = v;
        in_rsp_tag   = tag;
        in_rsp_data  = {4{tag}} + 64'd7;
        if (v) begin
            r.data = {4{tag}} + 64'd7;
            r.tag  = tag;
            exp_rsp_q.push_back(r);
        end
    endtask

    // Stimulus-side recorder: each accepted request becomes an expected output.
    always @(negedge clk) begin
        if (!reset && in_req_valid && in_req_ready)
            exp_req_q.push_back({in_req_rw, in_req_addr, in_req_data, in_req_byteen, in_req_tag});
    end

    // Request monitor: compares every downstream handshake against the queue head.
    always @(negedge clk) begin
        req_t e;
        if (!reset && out_req_valid && out_req_ready) begin
            if (exp_req_q.size() == 0) begin
                chk("req_unexpected", {48'd0, out_req_tag}, 64'hFFFF_FFFF);
            end else begin
                e = exp_req_q.pop_front();
                chk("req_tag",    {48'd0, out_req_tag},    {48'd0, e.tag});
                chk("req_rw",     {63'd0, out_req_rw},     {63'd0, e.rw});
                chk("req_addr",   {32'd0, out_req_addr},   {32'd0, e.addr});
                chk("req_data",   out_req_data,            e.data);
                chk("req_byteen", {56'd0, out_req_byteen}, {56'd0, e.byteen});
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (out_rsp_valid && out_rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_unexpected", {48'd0, out_rsp_tag}, 64'hFFFF_FFFF);
            end else begin
                e = exp_rsp_q.pop_front();
                chk("rsp_tag",  {48'd0, out_rsp_tag}, {48'd0, e.tag});
                chk("rsp_data", out_rsp_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;
        logic [2:0] exp_p;
        reset         = 1'b1;
        out_req_ready = 1'b1;
        out_rsp_ready = 1'b1;
        flush_req     = 1'b0;
        set_req(1'b1, 1'b0, 16'h0001);
        set_rsp(1'b0, 16'h0);

        // Reset: everything idle even with a read offered.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", {63'd0, in_req_ready}, 64'd0);
            chk("rst_outv",  {63'd0, out_req_valid}, 64'd0);
            chk("rst_busy",  {63'd0, busy}, 64'd0);
            chk("rst_fdone", {63'd0, flush_done}, 64'd0);
        end
        next_cycle();
        reset = 1'b0;
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("post_rst_ready",   {63'd0, in_req_ready}, 64'd1);
        chk("post_rst_pending", {61'd0, pending}, 64'd0);

        // Six back-to-back reads against four credits.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_req(1'b1, 1'b0, 16'h0010 + 16'(i));
            @(negedge clk);
            chk("A_ready", {63'd0, in_req_ready}, (i < 4) ? 64'd1 : 64'd0);
            chk("A_outv",  {63'd0, out_req_valid}, (i >= 1 && i <= 4) ? 64'd1 : 64'd0);
            if (i >= 1 && i <= 4)
                chk("A_lat_tag", {48'd0, out_req_tag}, 64'h000F + 64'(i));
        end
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("A_pending", {61'd0, pending}, 64'd4);
        chk("A_busy",    {63'd0, busy}, 64'd1);

        // Response and read together at full credits, then simultaneous inc/dec.
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0020);
        set_rsp(1'b1, 16'h0501);
        @(negedge clk);
        chk("B1_ready", {63'd0, in_req_ready}, 64'd0);
        next_cycle();
        set_rsp(1'b0, 16'h0);
        @(negedge clk);
        chk("B2_pending", {61'd0, pending}, 64'd3);
        chk("B2_ready",   {63'd0, in_req_ready}, 64'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        set_rsp(1'b1, 16'h0502);
        @(negedge clk);
        chk("B3_pending", {61'd0, pending}, 64'd4);
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0021);
        set_rsp(1'b1, 16'h0503);
        @(negedge clk);
        chk("B4_pending", {61'd0, pending}, 64'd3);
        chk("B4_ready",   {63'd0, in_req_ready}, 64'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        set_rsp(1'b0, 16'h0);
        @(negedge clk);
        chk("B5_pending_same", {61'd0, pending}, 64'd3);
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0022);
        @(negedge clk);
        chk("B6_ready", {63'd0, in_req_ready}, 64'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("B7_pending", {61'd0, pending}, 64'd4);

        // Writes are never credit gated.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            set_req(1'b1, 1'b1, 16'h0030 + 16'(i));
            @(negedge clk);
            chk("C_ready", {63'd0, in_req_ready}, 64'd1);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("C_pending", {61'd0, pending}, 64'd4);
        next_cycle();
        @(negedge clk);
        chk("C_drained", {63'd0, out_req_valid}, 64'd0);

        // Bring pending to 3, then flush with responses two cycles apart.
        next_cycle();
        set_rsp(1'b1, 16'h0504);
        @(negedge clk);
        next_cycle();
        set_rsp(1'b0, 16'h0);
        @(negedge clk);
        chk("D_pending3", {61'd0, pending}, 64'd3);
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            flush_req = (k == 0 || k == 7);
            set_rsp(k == 2 || k == 4 || k == 6, 16'h0510 + 16'(k));
            set_req(k >= 1, 1'b1, 16'h0040 + 16'(k));
            @(negedge clk);
            exp_p = (k <= 2) ? 3'd3 : (k <= 4) ? 3'd2 : (k <= 6) ? 3'd1 : 3'd0;
            chk("D_ready",   {63'd0, in_req_ready}, (k == 0 || k == 8) ? 64'd1 : 64'd0);
            chk("D_fdone",   {63'd0, flush_done}, (k == 7) ? 64'd1 : 64'd0);
            chk("D_busy",    {63'd0, busy}, (k <= 7) ? 64'd1 : 64'd0);
            chk("D_pending", {61'd0, pending}, {61'd0, exp_p});
        end
        next_cycle();
        flush_req = 1'b0;
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("D_post_tag", {48'd0, out_req_tag}, 64'h0048);
        next_cycle();
        @(negedge clk);
        chk("D_idle_busy", {63'd0, busy}, 64'd0);

        // Flush with nothing outstanding: done two cycles after the request.
        next_cycle();
        flush_req = 1'b1;
        @(negedge clk);
        chk("E_fdone0", {63'd0, flush_done}, 64'd0);
        next_cycle();
        flush_req = 1'b0;
        @(negedge clk);
        chk("E_fdone1", {63'd0, flush_done}, 64'd0);
        chk("E_busy1",  {63'd0, busy}, 64'd1);
        next_cycle();
        @(negedge clk);
        chk("E_fdone2", {63'd0, flush_done}, 64'd1);
        next_cycle();
        @(negedge clk);
        chk("E_fdone3", {63'd0, flush_done}, 64'd0);
        chk("E_ready3", {63'd0, in_req_ready}, 64'd1);

        // Downstream stall: two reads buffer, third waits, order preserved.
        n_acc = 0;
        for (int g = 0; g < 7; g++) begin
            next_cycle();
            out_req_ready = (g >= 5);
            set_req(n_acc < 3, 1'b0, 16'h0060 + 16'(n_acc));
            @(negedge clk);
            chk("F_ready", {63'd0, in_req_ready},
                (g <= 1 || g == 6) ? 64'd1 : 64'd0);
            if (g == 5) chk("F_head_tag", {48'd0, out_req_tag}, 64'h0060);
            if (in_req_valid && in_req_ready) n_acc++;
        end
        chk("F_accepted", 64'(n_acc), 64'd3);
        next_cycle();
        set_req(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("F_drained", {63'd0, out_req_valid}, 64'd0);
        chk("F_pending", {61'd0, pending}, 64'd3);

        // Reset in the middle of a drain with two reads outstanding.
        next_cycle();
        set_rsp(1'b1, 16'h0520);
        @(negedge clk);
        next_cycle();
        set_rsp(1'b0, 16'h0);
        flush_req = 1'b1;
        @(negedge clk);
        chk("G_pending2", {61'd0, pending}, 64'd2);
        next_cycle();
        flush_req = 1'b0;
        @(negedge clk);
        chk("G_drain_busy",  {63'd0, busy}, 64'd1);
        chk("G_drain_ready", {63'd0, in_req_ready}, 64'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("G_rst_busy",  {63'd0, busy}, 64'd0);
        chk("G_rst_ready", {63'd0, in_req_ready}, 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("G_pending0", {61'd0, pending}, 64'd0);
        chk("G_busy0",    {63'd0, busy}, 64'd0);
        chk("G_fdone0",   {63'd0, flush_done}, 64'd0);
        chk("G_ready1",   {63'd0, in_req_ready}, 64'd1);
        next_cycle();
        @(negedge clk);
        chk("G_no_pulse", {63'd0, flush_done}, 64'd0);

        chk("left_req", 64'(exp_req_q.size()), 64'd0);
        chk("left_rsp", 64'(exp_rsp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
